// File: rtl/idma_buffer_lane_ctrl.sv
// Lane-window sequencer for the iDMA byte-granular dataflow buffer.
// Accepts one transfer descriptor at a time and, for every beat, generates
// the per-lane enable masks that gate buffer writes (in side) and buffer
// drains (out side). done_o pulses once both sides have moved len bytes.
module idma_buffer_lane_ctrl #(
    parameter int unsigned StrbWidth = 8,
    parameter int unsigned LenWidth  = 16,
    parameter int unsigned OffsWidth = $clog2(StrbWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [OffsWidth-1:0] req_in_offs_i,
    input  logic [OffsWidth-1:0] req_out_offs_i,
    input  logic [LenWidth-1:0]  req_len_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [StrbWidth-1:0] buf_in_valid_o,
    input  logic [StrbWidth-1:0] buf_in_ready_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [StrbWidth-1:0] out_mask_o,
    input  logic [StrbWidth-1:0] buf_out_valid_i,
    output logic [StrbWidth-1:0] buf_out_ready_o,
    output logic                 done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [OffsWidth-1:0]  in_offs_q, in_offs_d;
    logic [OffsWidth-1:0]  out_offs_q, out_offs_d;
    logic [LenWidth-1:0]   in_rem_q, in_rem_d;
    logic [LenWidth-1:0]   out_rem_q, out_rem_d;
    logic                  in_first_q, in_first_d;
    logic                  out_first_q, out_first_d;
    logic                  done_q, done_d;

    logic                  busy;
    logic [LenWidth:0]     in_n, out_n;
    logic [StrbWidth-1:0]  in_mask, out_mask;
    logic                  in_hs, out_hs;

    // Bytes moved by the current beat of one side: min(StrbWidth - offs, rem),
    // evaluated one bit wider than the length so the subtraction cannot wrap.
    function automatic logic [LenWidth:0] beat_bytes(
        input logic                 first,
        input logic [OffsWidth-1:0] offs,
        input logic [LenWidth-1:0]  rem
    );
        logic [LenWidth:0] start;
        logic [LenWidth:0] avail;
        logic [LenWidth:0] rem_w;
        start = first ? (LenWidth+1)'(offs) : '0;
        avail = (LenWidth+1)'(StrbWidth) - start;
        rem_w = (LenWidth+1)'(rem);
        return (rem_w < avail) ? rem_w : avail;
    endfunction

    // Contiguous run of n lanes starting at the beat's lane offset.
    function automatic logic [StrbWidth-1:0] lane_mask(
        input logic                 first,
        input logic [OffsWidth-1:0] offs,
        input logic [LenWidth:0]    n
    );
        logic [LenWidth:0] start;
        logic [LenWidth:0] lane;
        start = first ? (LenWidth+1)'(offs) : '0;
        for (int unsigned i = 0; i < StrbWidth; i++) begin
            lane = (LenWidth+1)'(i);
            lane_mask[i] = (lane >= start) && (lane < start + n);
        end
    endfunction

    // Per-side lane windows and the beat handshakes they gate. Readiness and
    // validity depend only on the mask and the buffer lanes, never on the
    // upstream valid / downstream ready, so no loop forms through the buffer.
    always_comb begin
        busy     = (state_q == BUSY);
        in_n     = beat_bytes(in_first_q, in_offs_q, in_rem_q);
        out_n    = beat_bytes(out_first_q, out_offs_q, out_rem_q);
        in_mask  = busy ? lane_mask(in_first_q, in_offs_q, in_n) : '0;
        out_mask = busy ? lane_mask(out_first_q, out_offs_q, out_n) : '0;

        in_ready_o     = busy && (in_rem_q != '0) && (&(buf_in_ready_i | ~in_mask));
        in_hs          = in_valid_i && in_ready_o;
        buf_in_valid_o = in_mask & {StrbWidth{in_hs}};

        out_valid_o     = busy && (out_rem_q != '0) && (&(buf_out_valid_i | ~out_mask));
        out_hs          = out_valid_o && out_ready_i;
        out_mask_o      = out_valid_o ? out_mask : '0;
        buf_out_ready_o = out_mask & {StrbWidth{out_hs}};
    end

    // Next-state logic. Completion is detected on the edge of the final
    // handshake, so done_o and req_ready_o rise together in the next cycle
    // and a waiting descriptor can be taken right then.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_d     = state_q;
        in_offs_d   = in_offs_q;
        out_offs_d  = out_offs_q;
        in_rem_d    = in_rem_q;
        out_rem_d   = out_rem_q;
        in_first_d  = in_first_q;
        out_first_d = out_first_q;
        done_d      = 1'b0;
        req_ready_o = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    in_offs_d   = req_in_offs_i;
                    out_offs_d  = req_out_offs_i;
                    in_rem_d    = req_len_i;
                    out_rem_d   = req_len_i;
                    in_first_d  = 1'b1;
                    out_first_d = 1'b1;
                    // A zero-length transfer has nothing to move: complete it
                    // straight away instead of parking in BUSY for a cycle.
                    if (req_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (in_hs) begin
                    in_rem_d   = in_rem_q - in_n[LenWidth-1:0];
                    in_first_d = 1'b0;
                end
                if (out_hs) begin
                    out_rem_d   = out_rem_q - out_n[LenWidth-1:0];
                    out_first_d = 1'b0;
                end
                if ((in_rem_d == '0) && (out_rem_d == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset abandons any transfer silently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            in_offs_q   <= '0;
            out_offs_q  <= '0;
            in_rem_q    <= '0;
            out_rem_q   <= '0;
            in_first_q  <= 1'b0;
            out_first_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            in_offs_q   <= in_offs_d;
            out_offs_q  <= out_offs_d;
            in_rem_q    <= in_rem_d;
            out_rem_q   <= out_rem_d;
            in_first_q  <= in_first_d;
            out_first_q <= out_first_d;
            done_q      <= done_d;
        end
    end

    assign done_o = done_q;

endmodule

// File: tb/tb_idma_buffer_lane_ctrl.sv
// Directed testbench for idma_buffer_lane_ctrl (StrbWidth=8, LenWidth=16).
// Expected per-beat masks are pushed to queues when a descriptor is issued
// and popped as the DUT performs each in/out handshake.
module tb_idma_buffer_lane_ctrl;

    localparam int StrbWidth = 8;
    localparam int LenWidth  = 16;
    localparam int OffsWidth = 3;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [OffsWidth-1:0] req_in_offs_i;
    logic [OffsWidth-1:0] req_out_offs_i;
    logic [LenWidth-1:0]  req_len_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [StrbWidth-1:0] buf_in_valid_o;
    logic [StrbWidth-1:0] buf_in_ready_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [StrbWidth-1:0] out_mask_o;
    logic [StrbWidth-1:0] buf_out_valid_i;
    logic [StrbWidth-1:0] buf_out_ready_o;
    logic                 done_o;

    int checks = 0;
    int errors = 0;

    logic [StrbWidth-1:0] exp_in[$];
    logic [StrbWidth-1:0] exp_out[$];

    idma_buffer_lane_ctrl #(
        .StrbWidth(StrbWidth),
        .LenWidth (LenWidth)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_in_offs_i  (req_in_offs_i),
        .req_out_offs_i (req_out_offs_i),
        .req_len_i      (req_len_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .buf_in_valid_o (buf_in_valid_o),
        .buf_in_ready_i (buf_in_ready_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_mask_o     (out_mask_o),
        .buf_out_valid_i(buf_out_valid_i),
        .buf_out_ready_o(buf_out_ready_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
        end
    endtask

    // Reference model: fill lanes one byte at a time from the offset,
    // starting a new beat whenever the lane index runs off the top.
    task automatic push_model(input int io, input int oo, input int ln);
        for (int s = 0; s < 2; s++) begin
            int rem;
            int pos;
            logic [StrbWidth-1:0] m;
            rem = ln;
            pos = (s == 0) ? io : oo;
            while (rem > 0) begin
                m = '0;
                for (int lane = pos; lane < StrbWidth && rem > 0; lane++) begin
                    m[lane] = 1'b1;
                    rem--;
                end
                if (s == 0) exp_in.push_back(m);
                else        exp_out.push_back(m);
                pos = 0;
            end
        end
    endtask

    task automatic accept(input int io, input int oo, input int ln);
        @(negedge clk_i);
        req_valid_i     = 1'b1;
        req_in_offs_i   = OffsWidth'(io);
        req_out_offs_i  = OffsWidth'(oo);
        req_len_i       = LenWidth'(ln);
        in_valid_i      = 1'b0;
        out_ready_i     = 1'b0;
        buf_in_ready_i  = '1;
        buf_out_valid_i = '1;
        #1;
        check("req_ready_at_accept", req_ready_o, 1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        push_model(io, oo, ln);
    endtask

    // Runs beats until done_o; every cycle compares all handshake outputs
    // against the queue heads. Returns in the done cycle (sampled, pre-edge).
    task automatic run_beats(input string name, input int budget,
                             input logic [StrbWidth-1:0] in_pat, input int in_stall,
                             input logic [StrbWidth-1:0] out_pat, input int out_stall,
                             input bit rand_hs, input bit zero_len);
        bit pending;
        bit finished;
        bit e_in_rdy;
        bit e_out_vld;
        bit hs;
        logic [StrbWidth-1:0] f_in;
        logic [StrbWidth-1:0] f_out;
        pending  = zero_len;
        finished = 1'b0;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk_i);
            in_valid_i      = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready_i     = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            buf_in_ready_i  = (cyc < in_stall)  ? in_pat  : '1;
            buf_out_valid_i = (cyc < out_stall) ? out_pat : '1;
            #1;
            f_in      = (exp_in.size()  != 0) ? exp_in[0]  : '0;
            f_out     = (exp_out.size() != 0) ? exp_out[0] : '0;
            e_in_rdy  = (exp_in.size()  != 0) && (&(buf_in_ready_i  | ~f_in));
            e_out_vld = (exp_out.size() != 0) && (&(buf_out_valid_i | ~f_out));
            check({name, ".in_ready"},     in_ready_o,      e_in_rdy);
            check({name, ".buf_in_valid"}, buf_in_valid_o,  (e_in_rdy && in_valid_i) ? f_in : '0);
            check({name, ".out_valid"},    out_valid_o,     e_out_vld);
            check({name, ".out_mask"},     out_mask_o,      e_out_vld ? f_out : '0);
            check({name, ".buf_out_ready"}, buf_out_ready_o, (e_out_vld && out_ready_i) ? f_out : '0);
            check({name, ".done"},         done_o,          pending);
            check({name, ".req_ready"},    req_ready_o,     pending);
            if (pending) begin
                finished = 1'b1;
            end else begin
                hs = 1'b0;
                if (e_in_rdy && in_valid_i) begin
                    void'(exp_in.pop_front());
                    hs = 1'b1;
                end
                if (e_out_vld && out_ready_i) begin
                    void'(exp_out.pop_front());
                    hs = 1'b1;
                end
                pending = hs && (exp_in.size() == 0) && (exp_out.size() == 0);
            end
        end
        if (!finished) check({name, ".timeout"}, 0, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".req_ready"},     req_ready_o,     1);
        check({name, ".in_ready"},      in_ready_o,      0);
        check({name, ".buf_in_valid"},  buf_in_valid_o,  0);
        check({name, ".out_valid"},     out_valid_o,     0);
        check({name, ".out_mask"},      out_mask_o,      0);
        check({name, ".buf_out_ready"}, buf_out_ready_o, 0);
        check({name, ".done"},          done_o,          0);
    endtask

    initial begin
        rst_ni          = 1'b0;
        req_valid_i     = 1'b0;
        req_in_offs_i   = '0;
        req_out_offs_i  = '0;
        req_len_i       = '0;
        in_valid_i      = 1'b1;
        out_ready_i     = 1'b1;
        buf_in_ready_i  = '1;
        buf_out_valid_i = '1;

        // Reset values with handshake inputs active.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("post_reset");

        // Offset window 3/5/10: in F8,1F; out E0,7F.
        accept(3, 5, 10);
        run_beats("xfer_3_5_10", 20, '1, 0, '1, 0, 1'b0, 1'b0);

        // Zero length: done in the cycle right after acceptance, no beats.
        accept(0, 0, 0);
        run_beats("len0", 5, '1, 0, '1, 0, 1'b0, 1'b1);

        // Lane wrap: 80 then 01 on both sides.
        accept(7, 7, 2);
        run_beats("wrap_7_7_2", 20, '1, 0, '1, 0, 1'b0, 1'b0);

        // In-side lane 4 stalled for three cycles.
        accept(0, 0, 8);
        run_beats("in_stall", 20, 8'hEF, 3, '1, 0, 1'b0, 1'b0);

        // Out-side lane 2 missing for three cycles; a second descriptor is
        // held on req_valid_i and must only be taken in the done cycle.
        accept(2, 0, 6);
        req_valid_i    = 1'b1;
        req_in_offs_i  = 3'd1;
        req_out_offs_i = 3'd6;
        req_len_i      = 16'd9;
        run_beats("out_stall", 20, '1, 0, 8'hFB, 3, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        push_model(1, 6, 9);
        run_beats("held_1_6_9", 20, '1, 0, '1, 0, 1'b0, 1'b0);

        // Long transfer with random in_valid / out_ready.
        accept(5, 2, 21);
        run_beats("random_5_2_21", 200, '1, 0, '1, 0, 1'b1, 1'b0);

        // Reset after the first in beat of a len=20 transfer.
        accept(0, 0, 20);
        @(negedge clk_i);
        in_valid_i      = 1'b1;
        out_ready_i     = 1'b0;
        buf_in_ready_i  = '1;
        buf_out_valid_i = '0;
        #1;
        check("rst_xfer.in_ready", in_ready_o, 1);
        check("rst_xfer.buf_in_valid", buf_in_valid_o, 8'hFF);
        check("rst_xfer.out_valid", out_valid_o, 0);
        @(negedge clk_i);
        rst_ni          = 1'b0;
        out_ready_i     = 1'b1;
        buf_out_valid_i = '1;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) begin
            @(negedge clk_i);
            check("mid_reset.done_hold", done_o, 0);
        end
        rst_ni = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            #1;
            check_reset_outputs("after_reset");
        end
        exp_in.delete();
        exp_out.delete();
        accept(1, 3, 4);
        run_beats("fresh_1_3_4", 20, '1, 0, '1, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/idma_buffer_lane_ctrl.md
# idma_buffer_lane_ctrl

Per-transfer lane-window sequencer for the byte-granular dataflow buffer in the iDMA backend. It accepts one transfer descriptor at a time, holding an in-side lane offset, an out-side lane offset and a byte length. For every beat it generates the per-byte enable masks that gate which buffer lanes are written on the in side and drained on the out side. It sits between the read/write beat streams and the buffer's per-lane valid/ready ports, and signals completion once both sides have moved exactly `len` bytes.

## Interface
- `StrbWidth`, default 8: buffer width in bytes; power of two, at least 2.
- `LenWidth`, default 16: width of the transfer length in bytes.
- `OffsWidth`, default `$clog2(StrbWidth)`: derived; not to be overridden.
- `clk_i` in, 1: clock.
- `rst_ni` in, 1: asynchronous active-low reset.
- `req_valid_i` in, 1: descriptor valid.
- `req_ready_o` out, 1: descriptor accepted when both valid and ready are high.
- `req_in_offs_i` in, OffsWidth: first in-beat lane offset.
- `req_out_offs_i` in, OffsWidth: first out-beat lane offset.
- `req_len_i` in, LenWidth: transfer length in bytes; 0 is legal.
- `in_valid_i` in, 1: an in beat is present (already lane-aligned upstream).
- `in_ready_o` out, 1: the in beat is consumed.
- `buf_in_valid_o` out, StrbWidth: per-lane valid to the buffer input.
- `buf_in_ready_i` in, StrbWidth: per-lane ready from the buffer input.
- `out_valid_o` out, 1: an out beat is available.
- `out_ready_i` in, 1: the consumer takes the out beat.
- `out_mask_o` out, StrbWidth: byte strobe of the current out beat.
- `buf_out_valid_i` in, StrbWidth: per-lane valid from the buffer output.
- `buf_out_ready_o` out, StrbWidth: per-lane ready to the buffer output.
- `done_o` out, 1: single-cycle pulse when a transfer completes.

## Operation
- FSM states:
  - IDLE: `req_ready_o`=1. On acceptance, latch `in_offs`, `out_offs` and `len`. Set `in_rem = out_rem = len`, set `in_first = out_first = 1`, then go to BUSY.
  - BUSY: when `in_rem==0` and `out_rem==0` (including len=0), register `done_o`=1 and go to IDLE.
- Per-side mask, computed identically on each side:
  - `offs = first ? side_offs : 0`.
  - `n = min(StrbWidth - offs, rem)`.
  - `mask = ((1<<n)-1) << offs`.
  - `mask` is 0 when the side is not BUSY or `rem==0`.
  - Width arithmetic uses LenWidth+1 bits so there is no overflow.
- In side:
  - `in_ready_o = BUSY & in_rem!=0 & &(buf_in_ready_i | ~in_mask)`.
  - `buf_in_valid_o = in_mask & {StrbWidth{in_valid_i & in_ready_o}}`.
  - On handshake: `in_rem -= n`, `in_first <= 0`.
- Out side:
  - `out_valid_o = BUSY & out_rem!=0 & &(buf_out_valid_i | ~out_mask)`.
  - `out_mask_o = out_mask` while `out_valid_o` is high, 0 otherwise.
  - `buf_out_ready_o = out_mask & {StrbWidth{out_valid_o & out_ready_i}}`.
  - On handshake: `out_rem -= n`, `out_first <= 0`.
- The two sides advance independently. A side whose `rem` is 0 holds its ready/valid low until the transfer ends.
- No combinational path from `buf_in_valid_o` to `in_ready_o`, or from `buf_out_ready_o` to `out_valid_o`.
- `req_*` inputs are ignored while BUSY.

## Timing
- Reset values: state IDLE, `req_ready_o`=1; `in_ready_o`, `buf_in_valid_o`, `out_valid_o`, `out_mask_o`, `buf_out_ready_o` and `done_o` are all 0.
- Descriptor accepted at edge t; the first in/out handshakes are possible in cycle t+1.
- Final handshake (the last of both sides) at edge k: `done_o`=1 and `req_ready_o`=1 in cycle k+1. A new descriptor can be accepted in that same cycle.
- len=0 accepted at t: `done_o` pulses in cycle t+1, with no beats on either side.
- Simultaneous final in and out handshakes in the same cycle are counted once each; `done_o` still fires in the next cycle.
- Reset mid-transfer: return to IDLE immediately. Counters are cleared, all outputs take their reset values, and no `done_o` is issued.

## Test plan
- `StrbWidth`=8, in_offs=3, out_offs=5, len=10 -> in masks 0xF8 then 0x1F; out masks 0xE0 then 0x7F; `done_o` one cycle after the later final handshake.
- len=0, accepted at t -> no `in_ready_o`/`out_valid_o` ever; `done_o` high exactly in cycle t+1; `req_ready_o` high in t+1.
- in_offs=7, out_offs=7, len=2 -> in masks 0x80, 0x01; out masks 0x80, 0x01 (the lane wrap splits the transfer across two beats).
- Transfer 0/0/8, `buf_in_ready_i`=0xEF (lane 4 stalled) -> `in_ready_o`=0 and `buf_in_valid_o`=0; `in_rem` stays at 8 until lane 4 is ready, then one beat with mask 0xFF.
- Out-side stall: `buf_out_valid_i` missing one masked lane -> `out_valid_o`=0 and `buf_out_ready_o`=0. A second descriptor held at `req_valid_i` is accepted only in the `done_o` cycle.
- `rst_ni` asserted after the first in beat of a len=20 transfer -> all outputs at reset values, `done_o` never pulses; a fresh len=4 transfer afterwards completes normally.
